// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan controller with blanking gaps,
// leading-zero suppression and frame-aligned display updates via valid/ready.
module seg_scan_ctrl #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    input  logic        lz_en,
    output logic [3:0]  dec_d,
    output logic [3:0]  an,
    output logic        frame_done
);

    typedef enum logic {BLANK, SHOW} state_t;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SLOT_PRE   = CNT_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      disp;
    logic [15:0]      pending;

    logic        boundary;
    logic [15:0] disp_next;
    logic [1:0]  idx_next;
    logic [3:0]  nib_next;
    logic        zero_above;
    logic [3:0]  lit_an;

    // The pending register is full exactly when upd_ready is low, so the ready
    // flop doubles as the pending-valid flag.
    always_comb begin
        boundary  = (state == SHOW) && (cnt == SLOT_LAST) && (idx == 2'd3);
        disp_next = disp;
        if (boundary && !upd_ready) begin
            disp_next = pending;
        end
        idx_next = idx + 2'd1;
        case (idx_next)
            2'd0:    nib_next = disp_next[3:0];
            2'd1:    nib_next = disp_next[7:4];
            2'd2:    nib_next = disp_next[11:8];
            default: nib_next = disp_next[15:12];
        endcase
        case (idx)
            2'd3:    zero_above = (disp[15:12] == 4'h0);
            2'd2:    zero_above = (disp[15:8] == 8'h00);
            2'd1:    zero_above = (disp[15:4] == 12'h000);
            default: zero_above = 1'b0;
        endcase
        lit_an = (lz_en && zero_above) ? 4'b1111 : ~(4'b0001 << idx);
    end

    // dec_d is only reloaded on entry to BLANK, while every anode is dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            idx        <= 2'd0;
            cnt        <= '0;
            disp       <= 16'h0000;
            pending    <= 16'h0000;
            an         <= 4'b1111;
            dec_d      <= 4'h0;
            upd_ready  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (idx == 2'd3) && (cnt == SLOT_PRE);
            disp       <= disp_next;
            case (state)
                BLANK: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        an    <= lit_an;
                    end
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt   <= '0;
                        state <= BLANK;
                        idx   <= idx_next;
                        an    <= 4'b1111;
                        dec_d <= nib_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        an  <= lit_an;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                    an    <= 4'b1111;
                end
            endcase
            if (boundary && !upd_ready) begin
                upd_ready <= 1'b1;
            end else if (upd_valid && upd_ready) begin
                pending   <= upd_data;
                upd_ready <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scan controller for the 4-digit scoreboard display.
- Drives the single shared hex-to-seven-segment decoder with one digit code at a time and selects the matching digit anode.
- Inserts an anode blanking gap at every digit switch so the decoder output settles before a digit lights.
- Accepts new 4-nibble display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- CLK_DIV, 100000: clock cycles per digit slot (blank + show). Must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be >= 1.
- CNT_W, 17: slot counter width. Must satisfy 2^CNT_W > CLK_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- upd_valid  in  1  new display value offered
- upd_data  in  16  four 4-bit digit codes; [3:0]=digit0 (rightmost) … [15:12]=digit3
- upd_ready  out  1  controller can accept upd_data
- lz_en  in  1  leading-zero suppression enable (level, sampled every cycle)
- dec_d  out  4  digit code to shared decoder input
- an  out  4  digit anodes, active-low, one-hot-low when lit
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync release):
  - state=BLANK, digit index idx=0, slot counter cnt=0.
  - Display register disp=16'h0000, pending register empty.
  - Outputs: an=4'b1111, dec_d=4'h0, upd_ready=1, frame_done=0.
  - Reset mid-frame or mid-handshake discards disp and pending; no partial state survives.
- FSM with two states:
  - BLANK: an=4'b1111 for BLANK_CYCLES cycles; then go to SHOW.
  - SHOW: an = ~(4'b0001 << idx), unless the digit is suppressed (an=4'b1111). Lasts CLK_DIV-BLANK_CYCLES cycles.
  - End of SHOW: idx <= (idx+1) mod 4, cnt <= 0, state <= BLANK.
- Counter: cnt counts 0..CLK_DIV-1 within each slot. Slot period is exactly CLK_DIV cycles; frame period is exactly 4*CLK_DIV cycles.
- dec_d is registered. It updates to disp[4*idx+3:4*idx] on the first cycle of BLANK and holds through SHOW. It never changes while any anode is low.
- Leading-zero suppression (lz_en=1):
  - Digit k (k=3,2,1) is suppressed if its nibble and all higher nibbles in disp are 0.
  - Digit 0 is never suppressed.
  - Evaluation uses disp, not pending data.
  - lz_en=0: all digits lit.
- Handshake:
  - Transfer occurs when upd_valid&&upd_ready at a rising edge; upd_data is captured into pending.
  - upd_ready goes 0 the next cycle.
  - upd_valid is ignored while upd_ready=0.
- Frame boundary (last SHOW cycle of idx=3):
  - frame_done=1 for exactly that cycle.
  - If pending is full, disp <= pending at that edge and pending is emptied; upd_ready returns to 1 the following cycle.
  - Digit 0 of the new frame uses the new disp.
- Simultaneous transfer and boundary: data accepted on the boundary cycle goes to pending and is applied at the next boundary. It is not applied to the frame starting now.
- No combinational path from inputs to an, dec_d, or upd_ready; all outputs are registered.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2):
- Reset release, idle:
  - an=1111 for cycles 0-1, then 1110 for cycles 2-7.
  - Then 1111, then 1101 at 10-15, and so on through all four digits.
  - frame_done pulses at cycle 31 and every 32 cycles after; dec_d=0 throughout.
- Update 16'h1234 with upd_valid held:
  - upd_ready=1 at accept, then 0.
  - disp still shows 0000 until the next boundary.
  - Next frame: dec_d=4,3,2,1 during slots idx=0..3; upd_ready=1 the cycle after frame_done.
- lz_en=1, update 16'h0050:
  - idx=3 and idx=2 slots have an=1111 throughout.
  - idx=1 shows 1101 with dec_d=5; idx=0 shows 1110 with dec_d=0.
  - Update 16'h0000 instead: only idx=0 lights.
- Second upd_valid while upd_ready=0 (data 16'hAAAA after 16'h1234 accepted): ignored; display becomes 1234, never AAAA.
- upd_valid asserted exactly on the frame_done cycle with 16'h9876: the following frame still shows the old disp, and the frame after shows 6,7,8,9.
- rst_n pulsed low mid-SHOW of idx=2 with pending full:
  - an=1111, dec_d=0, upd_ready=1 immediately (async).
  - After release the display is all zeros and the scan restarts at idx=0 BLANK.
